// File: rtl/crc_mem_pkg.sv
// Shared widths and types for the CRC memory arbiter.
package crc_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } mem_req_t;

  // Bit 0 = m0 owns the returning read, bit 1 = m1 owns it.
  typedef logic [1:0] owner_t;

  function automatic logic req_active(input mem_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/crc_mem_starve_ctr.sv
// Saturating m1 starvation counter and burst lock register.
// Lock support is built only when ARB_LOCK_EN is defined.
module crc_mem_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic gnt1,
  input  logic m1_lock,
  output logic force1,
  output logic lock_hold
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // The count only measures unbroken denial; a grant or a dropped request restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (lock_hold || !req1 || gnt1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force1 = (starve_cnt == LIMIT);

`ifdef ARB_LOCK_EN
  // Lock is taken only on a granted cycle and released as soon as m1_lock drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_hold <= 1'b0;
    end else begin
      lock_hold <= m1_lock & (lock_hold | gnt1);
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m1_lock;
  assign lock_hold   = 1'b0;
`endif

endmodule

// File: rtl/crc_mem_arbiter.sv
// Two-master arbiter for the single-port 1024x32 CRC memory; m0 has priority,
// m1 is force-granted after STARVE_LIMIT denied cycles. Optional lock: ARB_LOCK_EN.
module crc_mem_arbiter
  import crc_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  // Handshake: a master holds its request while waitrequest is high; the access
  // is accepted in any cycle with the request high and waitrequest low, and read
  // data returns exactly one cycle later with readdatavalid (no backpressure).

  mem_req_t req0_b, req1_b, sel;
  logic     req0, req1, gnt0, gnt1;
  logic     force1, lock_hold;
  owner_t   rd_owner;

  // A simultaneous read and write is treated as a write.
  assign req0_b = '{address: m0_address, byteenable: m0_byteenable,
                    read: m0_read & ~m0_write, write: m0_write,
                    writedata: m0_writedata};
  assign req1_b = '{address: m1_address, byteenable: m1_byteenable,
                    read: m1_read & ~m1_write, write: m1_write,
                    writedata: m1_writedata};

  assign req0 = req_active(req0_b);
  assign req1 = req_active(req1_b);

  assign gnt1 = req1 & (~req0 | force1 | lock_hold);
  assign gnt0 = req0 & ~gnt1;

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  // With no grant the bus idles on m0's request fields.
  assign sel            = gnt1 ? req1_b : req0_b;
  assign mem_address    = sel.address;
  assign mem_byteenable = sel.byteenable;
  assign mem_writedata  = sel.writedata;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = sel.write & (gnt0 | gnt1);
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner <= '0;
    end else begin
      rd_owner <= {gnt1 & sel.read, gnt0 & sel.read};
    end
  end

  assign m0_readdatavalid = rd_owner[0];
  assign m1_readdatavalid = rd_owner[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  crc_mem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .req1     (req1),
    .gnt1     (gnt1),
    .m1_lock  (m1_lock),
    .force1   (force1),
    .lock_hold(lock_hold)
  );

endmodule

// File: tb/tb_crc_mem_arbiter.sv
// Self-checking bench for crc_mem_arbiter: memory responder, cycle reference
// model with read scoreboard, directed and random scenarios. Honours ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_crc_mem_arbiter;
  import crc_mem_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic              m1_lock = 1'b0;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b0;

  crc_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder (1-cycle registered q) ----------------
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] env_w;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        env_w = mem[mem_address];
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) env_w[8*b +: 8] = mem_writedata[8*b +: 8];
        mem[mem_address] <= env_w;
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W:0]   exp_q[$];      // {owner_is_m1, data} for reads in flight
  int                denied = 0;    // consecutive cycles m1 has waited
  bit                locked = 1'b0;
  bit                x_r0, x_r1, x_g0, x_g1;

  always @* begin
    x_r0 = m0_read | m0_write;
    x_r1 = m1_read | m1_write;
    x_g1 = x_r1 && (!x_r0 || denied >= STARVE_LIMIT || locked);
    x_g0 = x_r0 && !x_g1;
  end

  logic [ADDR_W-1:0] md_a;
  logic [BE_W-1:0]   md_be;
  logic [DATA_W-1:0] md_d;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      denied = 0;
      locked = 1'b0;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (x_g0 || x_g1) begin
        md_a  = x_g1 ? m1_address : m0_address;
        md_be = x_g1 ? m1_byteenable : m0_byteenable;
        md_d  = x_g1 ? m1_writedata : m0_writedata;
        if (x_g1 ? m1_write : m0_write) begin
          for (int b = 0; b < BE_W; b++)
            if (md_be[b]) ref_mem[md_a][8*b +: 8] = md_d[8*b +: 8];
        end else begin
          exp_q.push_back({x_g1, ref_mem[md_a]});
        end
      end
      if (locked) denied = 0;
      else if (x_r1 && !x_g1) denied = (denied + 1 > STARVE_LIMIT) ? STARVE_LIMIT : denied + 1;
      else denied = 0;
`ifdef ARB_LOCK_EN
      locked = m1_lock && (locked || x_g1);
`endif
    end
  end

  // ---------------- scoreboard ----------------
  logic sb_v0, sb_v1;
  always @(negedge clk) begin
    if (sb_en) begin
      sb_v0 = (exp_q.size() > 0) && !exp_q[0][DATA_W];
      sb_v1 = (exp_q.size() > 0) &&  exp_q[0][DATA_W];
      checks++;
      if (m0_waitrequest !== (x_r0 && !x_g0)) begin
        errors++; $display("FAIL sb_wait0: got %b expected %b t=%0t", m0_waitrequest, x_r0 && !x_g0, $time);
      end
      checks++;
      if (m1_waitrequest !== (x_r1 && !x_g1)) begin
        errors++; $display("FAIL sb_wait1: got %b expected %b t=%0t", m1_waitrequest, x_r1 && !x_g1, $time);
      end
      checks++;
      if (mem_chipselect !== (x_g0 || x_g1)) begin
        errors++; $display("FAIL sb_cs: got %b expected %b t=%0t", mem_chipselect, x_g0 || x_g1, $time);
      end
      if (x_g0 || x_g1) begin
        checks++;
        if (mem_address !== (x_g1 ? m1_address : m0_address) ||
            mem_write !== (x_g1 ? m1_write : m0_write)) begin
          errors++; $display("FAIL sb_addr: got %h/%b expected %h/%b t=%0t", mem_address, mem_write,
                             x_g1 ? m1_address : m0_address, x_g1 ? m1_write : m0_write, $time);
        end
        if (x_g1 ? m1_write : m0_write) begin
          checks++;
          if (mem_writedata !== (x_g1 ? m1_writedata : m0_writedata) ||
              mem_byteenable !== (x_g1 ? m1_byteenable : m0_byteenable)) begin
            errors++; $display("FAIL sb_wdata: got %h/%h t=%0t", mem_writedata, mem_byteenable, $time);
          end
        end
      end
      checks++;
      if (m0_readdatavalid !== sb_v0 || m1_readdatavalid !== sb_v1) begin
        errors++; $display("FAIL sb_valid: got %b%b expected %b%b t=%0t",
                           m1_readdatavalid, m0_readdatavalid, sb_v1, sb_v0, $time);
      end
      if (sb_v0 || sb_v1) begin
        checks++;
        if ((sb_v0 ? m0_readdata : m1_readdata) !== exp_q[0][DATA_W-1:0]) begin
          errors++; $display("FAIL sb_rdata: got %h expected %h t=%0t",
                             sb_v0 ? m0_readdata : m1_readdata, exp_q[0][DATA_W-1:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; idle();
    tick(); tick();
    sample();
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got v=%b%b cs=%b expected 000",
                         m1_readdatavalid, m0_readdatavalid, mem_chipselect);
    end
    checks++;
    if (mem_clken !== 1'b1) begin
      errors++; $display("FAIL reset_clken: got %b expected 1", mem_clken);
    end
    set_m0(1'b1, 1'b0, 10'h001, 4'hF, '0);
    set_m1(1'b1, 1'b0, 10'h002, 4'hF, '0);
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_wait: got w0=%b w1=%b expected w0=0 w1=1",
                         m0_waitrequest, m1_waitrequest);
    end
    idle();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    set_m0(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    tick();
    set_m0(1'b1, 1'b0, 10'h005, 4'hF, '0);
    sample();
    checks++;
    if (m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL wr_rd_early: got valid %b expected 0", m0_readdatavalid);
    end
    tick();
    idle();
    sample();
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL wr_rd_data: got v0=%b d=%h v1=%b expected 1 deadbeef 0",
                         m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    idle(); tick();
    for (int k = 0; k < 15; k++) begin
      set_m0(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 4'hF, '0);
      set_m1(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 4'hF, '0);
      sample();
      checks++;
      if (m1_waitrequest !== (k % 5 != 4) || m0_waitrequest !== (k % 5 == 4)) begin
        errors++; $display("FAIL starve_k%0d: got w0=%b w1=%b expected w0=%b w1=%b",
                           k, m0_waitrequest, m1_waitrequest, k % 5 == 4, k % 5 != 4);
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_byteenable();
    set_m0(1'b0, 1'b1, 10'h3FF, 4'hF, 32'hFFFFFFFF);
    tick();
    idle();
    set_m1(1'b0, 1'b1, 10'h3FF, 4'h3, 32'h0000ABCD);
    tick();
    idle();
    set_m0(1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    tick();
    idle();
    sample();
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hFFFFABCD) begin
      errors++; $display("FAIL byteenable: got v=%b d=%h expected 1 ffffabcd",
                         m0_readdatavalid, m0_readdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    idle();
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) set_m1(1'b1, 1'b0, 10'(k), 4'hF, '0);
      else idle();
      sample();
      if (k < 16) begin
        checks++;
        if (m1_waitrequest !== 1'b0) begin
          errors++; $display("FAIL b2b_wait_k%0d: got %b expected 0", k, m1_waitrequest);
        end
      end
      if (k >= 1) begin
        checks++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== ref_mem[k-1]) begin
          errors++; $display("FAIL b2b_data_k%0d: got v=%b d=%h expected 1 %h",
                             k, m1_readdatavalid, m1_readdata, ref_mem[k-1]);
        end
      end
      if (m1_readdatavalid === 1'b1) nvalid++;
      tick();
    end
    checks++;
    if (nvalid != 16) begin
      errors++; $display("FAIL b2b_count: got %0d expected 16", nvalid);
    end
    tick();
  endtask

  task automatic test_async_reset();
    idle(); tick();
    for (int k = 0; k < 5; k++) begin
      set_m0(1'b1, 1'b0, 10'(k), 4'hF, '0);
      set_m1(1'b1, 1'b0, 10'h007, 4'hF, '0);
      tick();
    end
    idle(); #1;
    checks++;
    if (m1_readdatavalid !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got valid %b expected 1", m1_readdatavalid);
    end
    reset = 1'b1; #1;
    checks++;
    if (m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL arst_drop: got valid %b expected 0", m1_readdatavalid);
    end
    tick();
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 10'h010, 4'hF, '0);
    set_m1(1'b1, 1'b0, 10'h011, 4'hF, '0);
    tick(); tick(); tick();
    reset = 1'b1; #2; reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if (m1_waitrequest !== (k != 4)) begin
        errors++; $display("FAIL arst_starve_k%0d: got w1=%b expected %b", k, m1_waitrequest, k != 4);
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_lock();
    idle(); tick();
`ifdef ARB_LOCK_EN
    m1_lock = 1'b1;
    set_m1(1'b1, 1'b0, 10'h020, 4'hF, '0);
    tick();
    set_m0(1'b1, 1'b0, 10'h030, 4'hF, '0);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) m1_lock = 1'b0;
      set_m1(1'b1, 1'b0, 10'(33 + k), 4'hF, '0);
      sample();
      checks++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0) begin
        errors++; $display("FAIL lock_k%0d: got w0=%b w1=%b expected 1 0", k, m0_waitrequest, m1_waitrequest);
      end
      tick();
    end
    sample();
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL lock_release: got w0=%b w1=%b expected 0 1", m0_waitrequest, m1_waitrequest);
    end
    tick();
`else
    m1_lock = 1'b1;
    set_m0(1'b1, 1'b0, 10'h030, 4'hF, '0);
    set_m1(1'b1, 1'b0, 10'h020, 4'hF, '0);
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      sample();
      checks++;
      if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
        errors++; $display("FAIL nolock_k%0d: got w0=%b w1=%b expected 0 1", k, m0_waitrequest, m1_waitrequest);
      end
      tick();
    end
`endif
    idle(); tick(); tick();
  endtask

  task automatic test_random();
    int op0, op1;
    for (int k = 0; k < 400; k++) begin
      op0 = $urandom_range(0, 4);
      op1 = $urandom_range(0, 4);
      set_m0(op0 == 1 || op0 == 2 || op0 == 4, op0 == 3 || op0 == 4,
             10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      set_m1(op1 == 1 || op1 == 2 || op1 == 4, op1 == 3 || op1 == 4,
             10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      m1_lock = ($urandom_range(0, 3) != 0);
      sample();
      checks++;
      if (m0_waitrequest === 1'b1 && m1_waitrequest === 1'b1) begin
        errors++; $display("FAIL rand_both_wait_k%0d: got w0=1 w1=1 expected one granted", k);
      end
      tick();
    end
    idle(); tick(); tick();
  endtask

  // ---------------- main ----------------
  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    sb_en = 1'b1;
    test_reset();
    test_write_read();
    test_starvation();
    test_byteenable();
    test_back_to_back();
    test_async_reset();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_mem_arbiter.md
Name: crc_mem_arbiter

Overview:
- Shares the single-port 1024x32 on-chip CRC memory between two Avalon-MM requesters.
- m0 is the Nios II data master and has priority. m1 is the CRC engine read/write port.
- At most one memory access is issued per cycle. Read data is returned one cycle after issue, tagged to the master that owns it.
- A starvation counter forces an m1 grant after a bounded wait.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- STARVE_LIMIT, 4, number of consecutive cycles m1 may be denied before it is force-granted; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  m0 word address
- m0_byteenable  in  BE_W  m0 byte lanes
- m0_read  in  1  m0 read request
- m0_write  in  1  m0 write request
- m0_writedata  in  DATA_W  m0 write data
- m0_waitrequest  out  1  m0 stall
- m0_readdata  out  DATA_W  m0 read data
- m0_readdatavalid  out  1  m0 read data valid
- m1_address, m1_byteenable, m1_read, m1_write, m1_writedata  in  same widths as m0  CRC engine request
- m1_lock  in  1  burst lock request (used only with ARB_LOCK_EN)
- m1_waitrequest, m1_readdata, m1_readdatavalid  out  same widths as m0  CRC engine response
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  BE_W  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  memory clock enable, tied to 1
- mem_readdata  in  DATA_W  memory q, valid one cycle after address

Behaviour:
- Requests: req0 = m0_read|m0_write; req1 = m1_read|m1_write. read and write asserted together on one master is illegal; write wins.
- Grant is combinational:
  - gnt1 = req1 & (~req0 | starve_cnt==STARVE_LIMIT | lock_hold).
  - gnt0 = req0 & ~gnt1.
- mX_waitrequest = reqX & ~gntX. An idle master sees waitrequest 0.
- Memory mux: the granted master drives mem_address, mem_byteenable and mem_writedata.
  - mem_chipselect = gnt0|gnt1.
  - mem_write = granted master's write.
  - With no grant, outputs are driven from m0 and chipselect is 0.
- Read latency: exactly 1 cycle.
  - Registered rd_owner[1:0] is set to {gnt1&read1, gnt0&read0} each cycle.
  - mX_readdatavalid = rd_owner[X].
  - mX_readdata = mem_readdata, driven for both masters; qualified only by valid.
- Back-to-back reads by the same master are allowed every cycle (full throughput).
- Starvation counter starve_cnt (4 bits):
  - Increments when req1 & ~gnt1.
  - Clears when gnt1 or when ~req1.
  - Saturates at STARVE_LIMIT.
- Write then read to the same address in consecutive cycles returns the new data; the memory is written on the first edge.
- Reset, asynchronous, mid-operation:
  - rd_owner=0, starve_cnt=0, lock_hold=0.
  - Both readdatavalid=0 immediately.
  - Any in-flight read is dropped and not replayed.
- Reset values of outputs: waitrequest follows requests combinationally; readdatavalid 0; mem_chipselect 0 if no requests.

Optional Feature:
- ARB_LOCK_EN
- Defined:
  - Registered lock_hold is set when gnt1 & m1_lock, and clears when m1_lock deasserts.
  - While lock_hold=1, m1 keeps the grant even against req0, and m0 stalls.
  - starve_cnt is frozen at 0 while lock_hold=1.
- Undefined: m1_lock is ignored and lock_hold is constant 0.

Decomposition:
- Package crc_mem_pkg holds:
  - ADDR_W/DATA_W/BE_W localparams.
  - A typedef for the request bundle {address, byteenable, read, write, writedata}.
  - A typedef for the 2-bit owner vector.
- One natural sub-module, crc_mem_starve_ctr: the saturating starvation counter plus lock_hold register. Its outputs are force1 and lock_hold.

Test Plan:
- m0 write addr 0x005 data 0xDEADBEEF BE=0xF, then m0 read 0x005 -> m0_readdatavalid high exactly 1 cycle after the read grant, m0_readdata=0xDEADBEEF, m1 valid stays 0.
- m0 and m1 both read continuously, STARVE_LIMIT=4 -> m1 is granted on every 5th cycle; m1_waitrequest low that cycle and m0_waitrequest high.
- m1 write 0x3FF BE=0x3 data 0x0000ABCD over a prior 0xFFFFFFFF, then m0 read 0x3FF -> 0xFFFFABCD.
- m0 idle, m1 reads 0x000..0x00F back-to-back -> 16 consecutive cycles with m1_readdatavalid=1 and waitrequest=0 throughout.
- Reset asserted the cycle after an m1 read grant -> m1_readdatavalid forced 0 asynchronously; starve_cnt=0 after release.
- ARB_LOCK_EN defined: m1_lock held for 8 m1 reads while m0 requests -> m0_waitrequest=1 for all 8 cycles; m0 is granted the cycle after m1_lock drops.
